fp_mult_result_stage: RTL

FP_MULT_RESULT_STAGE -- requirements
Module: fp_mult_result_stage

---
 rtl/fp_mult_result_stage.sv | 86 ++++++++
 1 files changed

// File: rtl/fp_mult_result_stage.sv
// Result buffer behind fp_mult: a small circular FIFO of product/status pairs,
// with sticky exception flags and an accepted-result counter.
module fp_mult_result_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_z,
  input  logic [7:0]       in_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic [7:0]       out_status,
  input  logic             flag_clr,
  output logic [5:0]       sticky_flags,
  output logic [CNT_W-1:0] result_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   z_mem [DEPTH];
  logic [7:0]    s_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic [5:0]    flags_nxt;
  logic          accept;
  logic          pop;

  assign out_valid  = (count != '0);
  assign accept     = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_z      = z_mem[rd_ptr];
  assign out_status = s_mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({accept, pop})
      2'b10:   count_nxt = count + (PW+1)'(1);
      2'b01:   count_nxt = count - (PW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Clear happens before the OR, so a clear+accept leaves only the new flags.
  always_comb begin
    flags_nxt = flag_clr ? 6'b0 : sticky_flags;
    if (accept) begin
      flags_nxt = flags_nxt | {(in_status[7:6] != 2'b11), in_status[5:1]};
    end
  end

  // in_ready is registered from the next occupancy, never from out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        z_mem[i] <= '0;
        s_mem[i] <= '0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      in_ready     <= 1'b1;
      sticky_flags <= '0;
      result_cnt   <= '0;
    end else begin
      if (accept) begin
        z_mem[wr_ptr] <= in_z;
        s_mem[wr_ptr] <= in_status;
        wr_ptr        <= wr_ptr + PW'(1);
        result_cnt    <= result_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count        <= count_nxt;
      in_ready     <= (count_nxt < (PW+1)'(DEPTH));
      sticky_flags <= flags_nxt;
    end
  end

endmodule
